mux_n_pipe: RTL and testbench
=============================

MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each data channel and of out_data.
REQ-002 Parameter N_IN, default 3, number of input channels; legal range 2..16.
REQ-003 Derived localparam SEL_W = max(1, ceil(log2(N_IN))), width of in_sel; not overridable.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 in_data  input  N_IN*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 in_sel  input  SEL_W  channel select, sampled with in_data.
REQ-010 flush  input  1  discard all held words.
REQ-011 out_valid  output  1  output word present.
REQ-012 out_ready  input  1  downstream accepts word.
REQ-013 out_data  output  WIDTH  selected data of oldest held word.
REQ-014 out_sel_err  output  1  oldest held word came from an out-of-range select.
REQ-015 err_sticky  output  1  an out-of-range select has been accepted since last clear.
REQ-016 err_clr  input  1  clears err_sticky.

Function
REQ-017 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-018 Accepted word stores in_sel-selected channel when in_sel < N_IN; otherwise stores all-zero data with error tag 1.
REQ-019 Storage is two entries (main, skid); occupancy states EMPTY, ONE, TWO.
REQ-020 Transitions: EMPTY+in -> ONE; ONE+in+out -> ONE; ONE+in only -> TWO; ONE+out only -> EMPTY; TWO+out -> ONE; otherwise hold.
REQ-021 in_ready is registered, equals 1 in EMPTY and ONE, 0 in TWO; it never depends combinationally on out_ready.
REQ-022 out_valid is 1 in ONE and TWO; out_data/out_sel_err show the oldest entry.
REQ-023 Latency: word accepted in cycle t appears on out_data in cycle t+1 when state at t is EMPTY.
REQ-024 Sustained throughput is one word per cycle while out_ready=1.
REQ-025 Words leave in acceptance order; none dropped or duplicated except by flush or reset.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_sel_err are held stable.
REQ-027 flush=1: output transfer in that cycle completes normally, input in that cycle is discarded (in_ready unaffected that cycle), next state EMPTY.
REQ-028 err_sticky sets on the cycle after accepting an out-of-range word; err_clr=1 clears it next cycle; simultaneous set and clear leaves it 1.
REQ-029 flush does not affect err_sticky; a discarded input in a flush cycle does not set it.
REQ-030 When N_IN is a power of two no select is out of range; out_sel_err and err_sticky remain 0.

Reset
REQ-031 While rst_n=0 at a rising edge: state EMPTY, out_valid=0, out_data=0, out_sel_err=0, err_sticky=0, in_ready=0.
REQ-032 In_ready is 1 from the first rising edge with rst_n=1.
REQ-033 Reset mid-operation discards held words and has priority over flush, err_clr and any transfer.

Verification
REQ-034 WIDTH=32, N_IN=3, in_data ch0=0x11111111 ch1=0x22222222 ch2=0x33333333, in_sel=1, out_ready=1 -> out_data=0x22222222, out_valid=1 one cycle later, out_sel_err=0.
REQ-035 in_sel=3 accepted -> next cycle out_data=0x00000000, out_sel_err=1, err_sticky=1; err_clr pulse -> err_sticky=0 next cycle.
REQ-036 out_ready=0, three back-to-back valid words A,B,C -> A,B accepted, in_ready=0 from cycle after B, C held upstream; out_ready=1 -> A,B,C delivered in order, no loss.
REQ-037 State TWO, flush=1 with out_ready=1 and in_valid=1 -> oldest word delivered that cycle, input discarded, out_valid=0 next cycle.
REQ-038 Continuous stream of 8 words, out_ready=1 -> 8 consecutive out_valid cycles, correct order, in_ready=1 throughout.
REQ-039 rst_n=0 asserted while state TWO with err_sticky=1 -> next cycle out_valid=0, out_data=0, err_sticky=0, in_ready=0; after release in_ready=1.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: selects one of N_IN packed input channels per accepted word and
// holds up to two selected words (main + skid) so that the upstream ready can
// be a pure register while still sustaining one word per cycle downstream.
//
// Handshake: a word moves across a port on any rising edge where that port's
// valid and ready are both 1. A producer holds valid and its payload steady
// until the transfer happens. in_ready comes only from registered occupancy,
// so it never depends combinationally on out_ready. out_valid and the output
// payload stay stable while out_ready is 0.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 3,
  localparam int SEL_W = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   main_data;
  logic               main_err;
  logic [WIDTH-1:0]   skid_data;
  logic               skid_err;

  logic [WIDTH-1:0]   sel_data;
  logic               sel_hit;
  logic               sel_err;
  logic               in_fire;
  logic               out_fire;

  // Channel select: an unmatched select yields zero data and an error tag.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_hit  = 1'b1;
      end
    end
  end

  assign sel_err = ~sel_hit;

  // A flush discards the incoming word, so it never counts as accepted.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  assign out_data    = main_data;
  assign out_sel_err = main_err;
  assign state_dbg   = state;

  // Occupancy FSM with registered ready/valid and the sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (flush) begin
        // Any output transfer this cycle completes; everything held is dropped.
        state     <= S_EMPTY;
        main_err  <= 1'b0;
        skid_err  <= 1'b0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        case (state)
          S_EMPTY: begin
            in_ready <= 1'b1;
            if (in_fire) begin
              main_data <= sel_data;
              main_err  <= sel_err;
              state     <= S_ONE;
              out_valid <= 1'b1;
            end
          end
          S_ONE: begin
            case ({in_fire, out_fire})
              2'b11: begin
                // Pass-through: new word replaces the departing one.
                main_data <= sel_data;
                main_err  <= sel_err;
              end
              2'b10: begin
                // Downstream stalled: park the new word behind the oldest.
                skid_data <= sel_data;
                skid_err  <= sel_err;
                state     <= S_TWO;
                in_ready  <= 1'b0;
              end
              2'b01: begin
                main_err  <= 1'b0;
                state     <= S_EMPTY;
                out_valid <= 1'b0;
              end
              default: begin
                state <= S_ONE;
              end
            endcase
          end
          S_TWO: begin
            // in_ready is 0 here, so only a departure can change occupancy.
            if (out_fire) begin
              main_data <= skid_data;
              main_err  <= skid_err;
              skid_err  <= 1'b0;
              state     <= S_ONE;
              in_ready  <= 1'b1;
            end
          end
          default: begin
            state     <= S_EMPTY;
            main_err  <= 1'b0;
            skid_err  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        endcase
      end

      // Set wins over clear so an error accepted alongside a clear is kept.
      if (in_fire && sel_err) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe (WIDTH=32, N_IN=3): reset, channel select,
// out-of-range select, stalls, flush, streaming and reset mid-operation.
module tb_mux_n_pipe;

  localparam int WIDTH = 32;
  localparam int N_IN  = 3;
  localparam int SEL_W = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]      in_sel;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_sel_err;
  logic                  err_sticky;
  logic                  err_clr;
  logic [1:0]            state_dbg;

  int checks;
  int errors;

  mux_n_pipe #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sel_err (out_sel_err),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr),
    .state_dbg   (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1,
                            input logic [WIDTH-1:0] c2, input logic [SEL_W-1:0] sel);
    in_valid = 1'b1;
    in_data  = {c2, c1, c0};
    in_sel   = sel;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 00000000", out_data); end
    checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err got %0b exp 0", out_sel_err); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got %0b exp 0", err_sticky); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_select();
    logic [WIDTH-1:0] exp_tab [3];
    exp_tab[0] = 32'h11111111;
    exp_tab[1] = 32'h22222222;
    exp_tab[2] = 32'h33333333;
    out_ready = 1'b1;
    for (int s = 2; s >= 0; s--) begin
      drive_word(32'h11111111, 32'h22222222, 32'h33333333, SEL_W'(s));
      step();
      idle_in();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sel%0d_valid got %0b exp 1", s, out_valid); end
      checks++; if (out_data !== exp_tab[s]) begin errors++; $display("FAIL sel%0d_data got %h exp %h", s, out_data, exp_tab[s]); end
      checks++; if (out_sel_err !== 1'b0) begin errors++; $display("FAIL sel%0d_err got %0b exp 0", s, out_sel_err); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sel%0d_drain got %0b exp 0", s, out_valid); end
    end
  endtask

  task automatic test_sel_err();
    out_ready = 1'b1;
    drive_word(32'h11111111, 32'h22222222, 32'h33333333, 2'd3);
    step();
    idle_in();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL selerr_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL selerr_data got %h exp 00000000", out_data); end
    checks++; if (out_sel_err !== 1'b1) begin errors++; $display("FAIL selerr_tag got %0b exp 1", out_sel_err); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL selerr_sticky got %0b exp 1", err_sticky); end
    step();
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL selerr_sticky_hold got %0b exp 1", err_sticky); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL selerr_clear got %0b exp 0", err_sticky); end
    // Set and clear on the same cycle: set wins.
    drive_word(32'h11111111, 32'h22222222, 32'h33333333, 2'd3);
    err_clr = 1'b1;
    step();
    idle_in();
    err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL selerr_set_clr got %0b exp 1", err_sticky); end
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL selerr_clear2 got %0b exp 0", err_sticky); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL selerr_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_word(32'hA0A0A0A0, 32'h0, 32'h0, 2'd0);
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a got %0b exp 1", in_ready); end
    checks++; if (out_data !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_data_a got %h exp a0a0a0a0", out_data); end
    drive_word(32'hB0B0B0B0, 32'h0, 32'h0, 2'd0);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_b got %0b exp 0", in_ready); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL b2b_state_two got %0d exp 2", state_dbg); end
    checks++; if (out_data !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_stable1 got %h exp a0a0a0a0", out_data); end
    drive_word(32'hC0C0C0C0, 32'h0, 32'h0, 2'd0);
    step();
    step();
    checks++; if (out_data !== 32'hA0A0A0A0) begin errors++; $display("FAIL b2b_stable2 got %h exp a0a0a0a0", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_hold got %0b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold got %0b exp 0", in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 32'hB0B0B0B0) begin errors++; $display("FAIL b2b_data_b got %h exp b0b0b0b0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_reopen got %0b exp 1", in_ready); end
    step();
    idle_in();
    checks++; if (out_data !== 32'hC0C0C0C0) begin errors++; $display("FAIL b2b_data_c got %h exp c0c0c0c0", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_c got %0b exp 1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_word(32'hD0D0D0D0, 32'h0, 32'h0, 2'd0);
    step();
    drive_word(32'hE0E0E0E0, 32'h0, 32'h0, 2'd0);
    step();
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL flush_pre_state got %0d exp 2", state_dbg); end
    checks++; if (out_data !== 32'hD0D0D0D0) begin errors++; $display("FAIL flush_oldest got %h exp d0d0d0d0", out_data); end
    drive_word(32'hF0F0F0F0, 32'h0, 32'h0, 2'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %0b exp 0", out_valid); end
    // Out-of-range word offered during a flush is discarded and sets nothing.
    drive_word(32'h0, 32'h0, 32'h0, 2'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle_in();
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL flush_no_err got %0b exp 0", err_sticky); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_word got %0b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [WIDTH-1:0] w;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = 32'h10000000 + 32'(i * 3 + 1);
      drive_word(32'h0, 32'h0, w, 2'd2);
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d_ready got %0b exp 1", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d_valid got %0b exp 1", i, out_valid); end
      checks++; if (out_data !== w) begin errors++; $display("FAIL stream%0d_data got %h exp %h", i, out_data, w); end
    end
    idle_in();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_word(32'h0, 32'h0, 32'h0, 2'd3);
    step();
    drive_word(32'h55555555, 32'h0, 32'h0, 2'd0);
    step();
    idle_in();
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL rstmid_pre_state got %0d exp 2", state_dbg); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL rstmid_pre_sticky got %0b exp 1", err_sticky); end
    rst_n = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got %h exp 00000000", out_data); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rstmid_sticky got %0b exp 0", err_sticky); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0b exp 0", in_ready); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got %0b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty got %0b exp 0", out_valid); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    test_reset();
    test_select();
    test_sel_err();
    test_back_to_back();
    test_flush();
    test_stream();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
